// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding and hazard unit.
package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // Where a read port's operand comes from this cycle.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_STAGE,
        SRC_CPL,
        SRC_BYP,
        SRC_REGFILE,
        SRC_WAIT
    } src_e;

    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Combinational priority resolution of one decode read port.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int NUM_FWD_STAGES = 2
) (
    input  logic [REG_ADDR_W-1:0]                addr,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_wen,
    input  logic [REG_ADDR_W*NUM_FWD_STAGES-1:0] fwd_addr,
    input  logic [XLEN*NUM_FWD_STAGES-1:0]       fwd_data,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_rdy,
    input  logic                                 cpl_valid,
    input  logic [REG_ADDR_W-1:0]                cpl_addr,
    input  logic [XLEN-1:0]                      cpl_data,
    input  logic                                 byp_vld,
    input  logic [REG_ADDR_W-1:0]                byp_addr,
    input  logic [XLEN-1:0]                      byp_data,
    input  logic [NUM_REGS-1:0]                  pending,
    output logic [XLEN-1:0]                      data,
    output logic                                 hit,
    output logic                                 valid
);

    src_e            src;
    logic            stage_match;
    logic            stage_rdy;
    logic [XLEN-1:0] stage_data;

    // Youngest matching stage wins; older stages are never consulted once one matches.
    always_comb begin
        stage_match = 1'b0;
        stage_rdy   = 1'b0;
        stage_data  = '0;
        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
            if (!stage_match && fwd_wen[k] && (fwd_addr[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                stage_match = 1'b1;
                stage_rdy   = fwd_rdy[k];
                stage_data  = fwd_data[k*XLEN +: XLEN];
            end
        end
    end

    // Pick the operand source in priority order.
    always_comb begin
        if (is_zero_reg(addr))
            src = SRC_ZERO;
        else if (stage_match)
            src = stage_rdy ? SRC_STAGE : SRC_WAIT;
        else if (cpl_valid && (cpl_addr == addr))
            src = SRC_CPL;
        else if (byp_vld && (byp_addr == addr))
            src = SRC_BYP;
        else if (pending[addr])
            src = SRC_WAIT;
        else
            src = SRC_REGFILE;
    end

    // Translate the chosen source into data/hit/valid.
    always_comb begin
        data  = '0;
        hit   = 1'b0;
        valid = 1'b1;
        unique case (src)
            SRC_ZERO:    hit = 1'b1;
            SRC_STAGE: begin
                data = stage_data;
                hit  = 1'b1;
            end
            SRC_CPL: begin
                data = cpl_data;
                hit  = 1'b1;
            end
            SRC_BYP: begin
                data = byp_data;
                hit  = 1'b1;
            end
            SRC_WAIT:    valid = 1'b0;
            default:     valid = 1'b1;
        endcase
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and hazard unit: per-port forwarding, pending scoreboard,
// one-cycle writeback bypass and saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int CNT_W          = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_RD_PORTS-1:0]              rs_req_i,
    input  logic [REG_ADDR_W*NUM_RD_PORTS-1:0]   rs_addr_i,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_rd_wen_i,
    input  logic [REG_ADDR_W*NUM_FWD_STAGES-1:0] fwd_rd_addr_i,
    input  logic [XLEN*NUM_FWD_STAGES-1:0]       fwd_rd_data_i,
    input  logic [NUM_FWD_STAGES-1:0]            fwd_rd_rdy_i,
    input  logic                                 iss_valid_i,
    input  logic                                 iss_long_i,
    input  logic [REG_ADDR_W-1:0]                iss_rd_addr_i,
    input  logic                                 cpl_valid_i,
    input  logic [REG_ADDR_W-1:0]                cpl_rd_addr_i,
    input  logic [XLEN-1:0]                      cpl_rd_data_i,
    input  logic                                 flush_i,
    output logic [XLEN*NUM_RD_PORTS-1:0]         rs_data_o,
    output logic [NUM_RD_PORTS-1:0]              rs_hit_o,
    output logic [NUM_RD_PORTS-1:0]              rs_valid_o,
    output logic                                 stall_o,
    output logic [NUM_REGS-1:0]                  pending_o,
    output logic [CNT_W-1:0]                     stall_cnt_o
);

    logic [NUM_REGS-1:0]   pending_p0;
    logic [NUM_REGS-1:0]   pending_nxt;
    logic                  byp_vld_p0;
    logic [REG_ADDR_W-1:0] byp_addr_p0;
    logic [XLEN-1:0]       byp_data_p0;
    logic [CNT_W-1:0]      stall_cnt_p0;

    logic iss_nz;
    logic waw_stall;
    logic iss_set;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_sel #(
            .XLEN           (XLEN),
            .NUM_FWD_STAGES (NUM_FWD_STAGES)
        ) u_sel (
            .addr      (rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
            .fwd_wen   (fwd_rd_wen_i),
            .fwd_addr  (fwd_rd_addr_i),
            .fwd_data  (fwd_rd_data_i),
            .fwd_rdy   (fwd_rd_rdy_i),
            .cpl_valid (cpl_valid_i),
            .cpl_addr  (cpl_rd_addr_i),
            .cpl_data  (cpl_rd_data_i),
            .byp_vld   (byp_vld_p0),
            .byp_addr  (byp_addr_p0),
            .byp_data  (byp_data_p0),
            .pending   (pending_p0),
            .data      (rs_data_o[p*XLEN +: XLEN]),
            .hit       (rs_hit_o[p]),
            .valid     (rs_valid_o[p])
        );
    end

    assign iss_nz    = !is_zero_reg(iss_rd_addr_i);
    // A second long-latency write to a register still in flight must wait (WAW).
    assign waw_stall = iss_valid_i & iss_long_i & iss_nz & pending_p0[iss_rd_addr_i];
    assign stall_o   = (|(rs_req_i & ~rs_valid_o)) | waw_stall;
    assign iss_set   = iss_valid_i & iss_long_i & iss_nz & ~stall_o & ~flush_i;

    assign pending_o   = pending_p0;
    assign stall_cnt_o = stall_cnt_p0;

    // Next scoreboard: completion clears, issue sets (set wins), flush wipes all.
    always_comb begin
        pending_nxt = pending_p0;
        if (cpl_valid_i)
            pending_nxt[cpl_rd_addr_i] = 1'b0;
        if (iss_set)
            pending_nxt[iss_rd_addr_i] = 1'b1;
        if (flush_i)
            pending_nxt = '0;
        pending_nxt[ZERO_REG] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending_p0 <= '0;
        else
            pending_p0 <= pending_nxt;
    end

    // Writeback bypass: each completion stays visible for exactly one more cycle
    // to cover the regfile write-to-read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_vld_p0  <= 1'b0;
            byp_addr_p0 <= '0;
            byp_data_p0 <= '0;
        end else begin
            byp_vld_p0  <= cpl_valid_i;
            byp_addr_p0 <= cpl_rd_addr_i;
            byp_data_p0 <= cpl_rd_data_i;
        end
    end

    // Saturating count of stalled cycles; survives flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_p0 <= '0;
        else if (stall_o && !(&stall_cnt_p0))
            stall_cnt_p0 <= stall_cnt_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
